// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, multicycle-op wait with watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int MC_MAX_CYCLES = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  branch_taken_i,
  input  logic                  mc_start_i,
  input  logic                  mc_done_i,
  output logic                  pc_write_o,
  output logic                  ifid_stall_o,
  output logic                  ifid_flush_o,
  output logic                  idex_stall_o,
  output logic                  idex_flush_o,
  output logic                  exmem_flush_o,
  output logic                  mc_timeout_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  localparam logic [7:0] MC_MAX = 8'(MC_MAX_CYCLES);

  state_t     state;
  logic [7:0] mc_cnt;
  logic       load_use;
  logic       br_flush;

  assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

  // Controls are combinational so the stall/flush takes effect on the same edge.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    br_flush      = 1'b0;
    if (!rst_n) begin
      pc_write_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (state == RUN) begin
      if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        br_flush     = 1'b1;
      end else if (mc_start_i && !mc_done_i) begin
        pc_write_o    = 1'b0;
        ifid_stall_o  = 1'b1;
        idex_stall_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end else if (load_use) begin
        pc_write_o   = 1'b0;
        ifid_stall_o = 1'b1;
        idex_flush_o = 1'b1;
      end
    end else if (!mc_done_i && (mc_cnt < MC_MAX)) begin
      pc_write_o    = 1'b0;
      ifid_stall_o  = 1'b1;
      idex_stall_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state        <= RUN;
      mc_cnt       <= '0;
      mc_timeout_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!branch_taken_i && mc_start_i && !mc_done_i) begin
            state  <= MC_WAIT;
            mc_cnt <= 8'd1;
          end
        end
        MC_WAIT: begin
          if (mc_done_i) begin
            state  <= RUN;
            mc_cnt <= '0;
          end else if (mc_cnt < MC_MAX) begin
            mc_cnt <= mc_cnt + 8'd1;
          end else begin
            // Watchdog expired: release the pipeline and latch the error.
            state        <= RUN;
            mc_cnt       <= '0;
            mc_timeout_o <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write_o && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (br_flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  logic unused_br_flush;
  assign unused_br_flush = br_flush;
  assign stall_cnt_o     = '0;
  assign flush_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios followed by randomized traffic against a cycle model.
module tb_pipe_ctrl;
  localparam int AW    = 5;
  localparam int MCMAX = 4;

  localparam logic [5:0] RST = 6'b001011;
  localparam logic [5:0] NRM = 6'b100000;
  localparam logic [5:0] BR  = 6'b101010;
  localparam logic [5:0] MCS = 6'b010101;
  localparam logic [5:0] LU  = 6'b010010;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs_i, id_rt_i, ex_rd_i;
  logic          id_uses_rt_i, ex_memread_i, branch_taken_i, mc_start_i, mc_done_i;
  logic          pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o, exmem_flush_o;
  logic          mc_timeout_o;
  logic [31:0]   stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.REG_ADDR_W(AW), .MC_MAX_CYCLES(MCMAX)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mc_start_i(mc_start_i), .mc_done_i(mc_done_i),
    .pc_write_o(pc_write_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_stall_o(idex_stall_o), .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
    .mc_timeout_o(mc_timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  int passed = 0;
  int total  = 0;

  // Model: number of stall cycles already issued for the pending multicycle op (0 = none).
  int          m_elapsed = 0;
  logic        m_to      = 1'b0;
  logic [31:0] m_stall   = '0;
  logic [31:0] m_flush   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic r, input logic mr, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic urt,
                      input logic br, input logic ms, input logic md);
    logic [5:0] exp;
    logic       lu;
    int         nx_el;
    logic       nx_to;
    rst_n = r; ex_memread_i = mr; ex_rd_i = rd; id_rs_i = rs; id_rt_i = rt;
    id_uses_rt_i = urt; branch_taken_i = br; mc_start_i = ms; mc_done_i = md;
    #2;
    lu    = mr && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
    nx_el = m_elapsed;
    nx_to = m_to;
    if (!r) begin
      exp = RST; nx_el = 0; nx_to = 1'b0;
    end else if (m_elapsed == 0) begin
      if (br)             exp = BR;
      else if (ms && !md) begin exp = MCS; nx_el = 1; end
      else if (lu)        exp = LU;
      else                exp = NRM;
    end else if (md) begin
      exp = NRM; nx_el = 0;
    end else if (m_elapsed < MCMAX) begin
      exp = MCS; nx_el = m_elapsed + 1;
    end else begin
      exp = NRM; nx_el = 0; nx_to = 1'b1;
    end
    chk({tag, "/ctrl"}, {26'd0, pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
                         idex_flush_o, exmem_flush_o}, {26'd0, exp});
    @(posedge clk_i); #1;
`ifdef PIPE_PERF_CNT_EN
    if (!r) begin
      m_stall = '0; m_flush = '0;
    end else begin
      if (!exp[5] && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if ((exp == BR) && (m_flush != 32'hFFFF_FFFF)) m_flush = m_flush + 1;
    end
`endif
    m_elapsed = nx_el;
    m_to      = nx_to;
    chk({tag, "/timeout"}, {31'd0, mc_timeout_o}, {31'd0, m_to});
    chk({tag, "/stall_cnt"}, stall_cnt_o, m_stall);
    chk({tag, "/flush_cnt"}, flush_cnt_o, m_flush);
  endtask

  initial begin
    // Reset with hazards and a multicycle start present: reset outputs must win.
    step("reset0", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("reset1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use on rs, then on rt, then rd=0, then rt match but rt unused.
    step("lu_rs",   1'b1, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_after",1'b1, 1'b0, 5'd0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rt",   1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rd0",  1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_nort", 1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch beats multicycle start and load-use.
    step("br_prio", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("br_next", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start with done in the same cycle: no wait.
    step("mc_imm",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Multicycle op completing 4 cycles after start; hazards ignored while waiting.
    step("mc_s",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mc_w1", 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mc_w2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mc_w3", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mc_d",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mc_done_no_timeout", {31'd0, mc_timeout_o}, 32'd0);

    // Watchdog: no done -> four stall cycles then release with sticky flag.
    step("wd_s",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("wd_w", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wd_rel", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wd_run", 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_sticky", {31'd0, mc_timeout_o}, 32'd1);
    step("wd_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_cleared", {31'd0, mc_timeout_o}, 32'd0);

    // Reset inside the wait abandons it without flagging.
    step("ra_s",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ra_w",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ra_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ra_run", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with a small register space so hazards are frequent.
    for (int i = 0; i < 1500; i++)
      step("rand", ($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-specifier width.
REQ-002 Parameter MC_MAX_CYCLES, default 32, multicycle watchdog limit in cycles (legal range 2..255).
REQ-003 Port clk_i, input, 1, clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 Port id_rs_i, input, REG_ADDR_W, rs of instruction in ID.
REQ-006 Port id_rt_i, input, REG_ADDR_W, rt of instruction in ID.
REQ-007 Port id_uses_rt_i, input, 1, ID instruction reads rt.
REQ-008 Port ex_memread_i, input, 1, EX instruction is a load.
REQ-009 Port ex_rd_i, input, REG_ADDR_W, destination register of EX instruction.
REQ-010 Port branch_taken_i, input, 1, EX branch resolved taken.
REQ-011 Port mc_start_i, input, 1, multicycle op entered EX this cycle.
REQ-012 Port mc_done_i, input, 1, multicycle unit result valid.
REQ-013 Ports pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o, exmem_flush_o, outputs, 1 each, pipeline-register controls.
REQ-014 Port mc_timeout_o, output, 1, sticky watchdog error flag.
REQ-015 Ports stall_cnt_o, flush_cnt_o, outputs, 32 each, performance counters.

Function
REQ-016 FSM states SHALL be RUN and MC_WAIT; a cycle counter mc_cnt SHALL track MC_WAIT occupancy.
REQ-017 Control outputs SHALL be combinational from state and current inputs, so they act on the same clock edge.
REQ-018 load-use hazard = ex_memread_i & ex_rd_i!=0 & (ex_rd_i==id_rs_i | (id_uses_rt_i & ex_rd_i==id_rt_i)).
REQ-019 RUN priority SHALL be: branch_taken_i > mc_start_i > load-use > normal.
REQ-020 RUN, branch_taken_i=1: ifid_flush_o=1, idex_flush_o=1, pc_write_o=1, all stalls 0; mc_start_i and load-use ignored; stay RUN.
REQ-021 RUN, mc_start_i=1 and mc_done_i=0: pc_write_o=0, ifid_stall_o=1, idex_stall_o=1, exmem_flush_o=1; next state MC_WAIT, mc_cnt<=1.
REQ-022 RUN, mc_start_i=1 and mc_done_i=1: normal outputs; stay RUN.
REQ-023 RUN, load-use: pc_write_o=0, ifid_stall_o=1, idex_flush_o=1, others 0; stay RUN (one-cycle bubble).
REQ-024 RUN normal: pc_write_o=1, all stall/flush outputs 0.
REQ-025 MC_WAIT, mc_done_i=0, mc_cnt<MC_MAX_CYCLES: outputs as REQ-021; mc_cnt increments.
REQ-026 MC_WAIT, mc_done_i=1: normal outputs; next state RUN; mc_cnt<=0.
REQ-027 MC_WAIT, mc_done_i=0, mc_cnt==MC_MAX_CYCLES: normal outputs, mc_timeout_o<=1 (sticky until reset), next state RUN.
REQ-028 Branch and load-use inputs SHALL be ignored in MC_WAIT.
REQ-029 mc_cnt width SHALL be 8 bits and SHALL not wrap under legal MC_MAX_CYCLES.

Reset
REQ-030 When rst_n=0 at a rising edge: state<=RUN, mc_cnt<=0, mc_timeout_o<=0, counters<=0.
REQ-031 While rst_n=0, outputs SHALL be pc_write_o=0, ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1, stalls 0, overriding FSM decode.
REQ-032 Reset asserted in MC_WAIT SHALL abandon the wait with no timeout flag set.

Configuration
REQ-033 With PIPE_PERF_CNT_EN defined: stall_cnt_o increments each cycle pc_write_o=0 (reset excluded), flush_cnt_o each cycle branch flush (REQ-020) occurs; both saturate at 32'hFFFFFFFF.
REQ-034 Without PIPE_PERF_CNT_EN: stall_cnt_o and flush_cnt_o SHALL be constant 0, no counter flops inferred; ports remain.

Verification
REQ-035 ex_memread_i=1, ex_rd_i=5, id_rs_i=5 -> one cycle pc_write_o=0, ifid_stall_o=1, idex_flush_o=1; stall_cnt_o=1 (if enabled).
REQ-036 Same as REQ-035 but ex_rd_i=0 -> no stall, pc_write_o=1.
REQ-037 branch_taken_i=1 with concurrent load-use and mc_start_i -> ifid_flush_o=idex_flush_o=1, pc_write_o=1, state stays RUN.
REQ-038 mc_start_i pulse, mc_done_i after 4 cycles -> pc_write_o=0 for 4 cycles, exmem_flush_o=1 those cycles, then normal; mc_timeout_o=0.
REQ-039 MC_MAX_CYCLES=4, mc_start_i with no mc_done_i -> release to RUN after 4 stall cycles, mc_timeout_o=1 until rst_n=0.
